// File: rtl/mv_seq_pkg.sv
// Shared types and defaults for the matrix-vector tile sequencer.
// Holds the FSM state encoding, default pipeline geometry and the vector-bank encoding.
package mv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        WAIT_WB,
        FIN
    } state_t;

    localparam int DEF_LANES    = 6;
    localparam int DEF_PIPE_LAT = 82;
    localparam int DEF_ACC_LAT  = 38;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/mv_delay_line.sv
// Fixed-depth token shift register with a mid tap, an end tap and an occupancy flag.
// Every stage is cleared together by reset or by the synchronous clear input.
module mv_delay_line #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    parameter int TAP_A = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap_a,
    output logic [WIDTH-1:0] tap_b,
    output logic             occupied
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: stages are reset, not left X; the sequencer reads occupancy to leave DRAIN.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tap_a = stage[TAP_A-1];
    assign tap_b = stage[DEPTH-1];

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < DEPTH; i++) occupied = occupied | (|stage[i]);
    end

endmodule

// File: rtl/mv_tile_sequencer.sv
// Sequences iterated y = M*x over a LANES-row tile array, ping-ponging vector banks.
// Issues BRAM reads, aligns accumulator controls and bursts per-lane write-back.
module mv_tile_sequencer
    import mv_seq_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int COL_W    = 9,
    parameter int GRP_W    = 8,
    parameter int ITER_W   = 16,
    parameter int MADDR_W  = 12,
    parameter int VADDR_W  = 10,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int ACC_LAT  = DEF_ACC_LAT,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [COL_W-1:0]   cols,
    input  logic [GRP_W-1:0]   groups,
    input  logic [ITER_W-1:0]  iterations,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               result_bank,
    output logic [MADDR_W-1:0] m_addr,
    output logic               m_en,
    output logic [VADDR_W-1:0] v_raddr,
    output logic               v_ren,
    output logic [VADDR_W-1:0] v_waddr,
    output logic               v_we,
    output logic [LANE_W-1:0]  wb_lane,
    output logic               acc_valid,
    output logic               acc_last
);

    localparam int VW = VADDR_W - 1;

    state_t             state, state_d;
    logic [COL_W-1:0]   cfg_cols, col_q;
    logic [GRP_W-1:0]   cfg_groups, grp_q;
    logic [ITER_W-1:0]  cfg_iters, iter_q;
    logic [MADDR_W-1:0] m_cnt;
    logic               rd_bank, wr_bank, res_bank, err_q;
    logic               wb_act;
    logic [LANE_W-1:0]  wb_lane_q;
    logic [VW-1:0]      wb_base;
    logic [1:0]         tok_in, tok_acc, tok_wb;
    logic               dl_occupied;
    logic [31:0]        m_words, v_words;
    logic               cfg_bad, feed, last_col, last_read, iter_done;
    logic               abort_hit, wb_first, wb_end;

    assign m_words   = 32'(groups) * 32'(cols);
    assign v_words   = 32'(groups) * 32'(LANES);
    assign cfg_bad   = (32'(cols) < 32'(LANES)) || (groups == '0) || (iterations == '0) ||
                       (m_words > (32'd1 << MADDR_W)) || (v_words > (32'd1 << VW));
    assign feed      = (state == FEED);
    assign last_col  = (col_q == cfg_cols - COL_W'(1));
    assign last_read = feed && last_col && (grp_q == cfg_groups - GRP_W'(1));
    assign iter_done = (iter_q + ITER_W'(1)) == cfg_iters;
    assign abort_hit = abort && (state != IDLE);

    // Token = {valid, last}; the end tap marks the accumulator result of a finished group.
    assign tok_in   = {feed, feed && last_col};
    assign wb_first = tok_wb[0];
    assign wb_end   = (wb_first && LANES == 1) || (wb_act && wb_lane_q == LANE_W'(LANES - 1));

    mv_delay_line #(
        .DEPTH (PIPE_LAT + ACC_LAT),
        .WIDTH (2),
        .TAP_A (PIPE_LAT)
    ) u_tok_dl (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (abort_hit),
        .din      (tok_in),
        .tap_a    (tok_acc),
        .tap_b    (tok_wb),
        .occupied (dl_occupied)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: next state defaults to the current one so no branch can infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start && !abort) state_d = cfg_bad ? FIN : FEED;
            FEED:    if (last_read) state_d = DRAIN;
            DRAIN:   if (!dl_occupied && !wb_act) state_d = WAIT_WB;
            WAIT_WB: state_d = iter_done ? FIN : FEED;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = FIN;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn || abort_hit) begin
            cfg_cols   <= '0;
            cfg_groups <= '0;
            cfg_iters  <= '0;
            col_q      <= '0;
            grp_q      <= '0;
            iter_q     <= '0;
            m_cnt      <= '0;
            rd_bank    <= BANK0;
            wr_bank    <= BANK0;
            res_bank   <= BANK0;
            err_q      <= rstn;   // abort reports an error, reset does not
            wb_act     <= 1'b0;
            wb_lane_q  <= '0;
            wb_base    <= '0;
        end else begin
            if (wb_end) wb_base <= wb_base + VW'(LANES);
            if (wb_first && LANES > 1) begin
                wb_act    <= 1'b1;
                wb_lane_q <= LANE_W'(1);
            end else if (wb_act) begin
                if (wb_lane_q == LANE_W'(LANES - 1)) begin
                    wb_act    <= 1'b0;
                    wb_lane_q <= '0;
                end else begin
                    wb_lane_q <= wb_lane_q + LANE_W'(1);
                end
            end

            case (state)
                IDLE: if (start && !abort) begin
                    cfg_cols   <= cols;
                    cfg_groups <= groups;
                    cfg_iters  <= iterations;
                    err_q      <= cfg_bad;
                    col_q      <= '0;
                    grp_q      <= '0;
                    iter_q     <= '0;
                    m_cnt      <= '0;
                    rd_bank    <= BANK0;
                    wr_bank    <= BANK1;
                    res_bank   <= BANK0;
                    wb_base    <= '0;
                end
                FEED: begin
                    if (last_read) begin
                        col_q <= '0;
                        grp_q <= '0;
                        m_cnt <= '0;
                    end else begin
                        m_cnt <= m_cnt + MADDR_W'(1);
                        if (last_col) begin
                            col_q <= '0;
                            grp_q <= grp_q + GRP_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                WAIT_WB: begin
                    rd_bank <= wr_bank;
                    wr_bank <= rd_bank;
                    wb_base <= '0;
                    if (iter_done) begin
                        iter_q   <= '0;
                        res_bank <= wr_bank;
                    end else begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state == FEED) || (state == DRAIN) || (state == WAIT_WB);
    assign done        = (state == FIN);
    assign err         = err_q;
    assign result_bank = res_bank;
    assign m_addr      = m_cnt;
    assign m_en        = feed;
    assign v_raddr     = {rd_bank, VW'(col_q)};
    assign v_ren       = feed;
    assign acc_valid   = tok_acc[1];
    assign acc_last    = tok_acc[0];
    assign v_we        = wb_first || wb_act;
    assign wb_lane     = wb_first ? '0 : wb_lane_q;
    assign v_waddr     = {wr_bank, wb_base + VW'(wb_lane)};

endmodule

// File: tb/tb_mv_tile_sequencer.sv
// Randomised bench for mv_tile_sequencer against an event-list reference model.
// Expected read, accumulate and write-back traces are derived from the configuration alone.
module tb_mv_tile_sequencer;

    localparam int L = 2, P = 4, A = 2;
    localparam int COL_W = 9, GRP_W = 8, ITER_W = 16, MADDR_W = 6, VADDR_W = 10;
    localparam int LANE_W = 1;
    localparam int BANK_SPAN = 1 << (VADDR_W - 1);

    logic               clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [COL_W-1:0]   cols = '0;
    logic [GRP_W-1:0]   groups = '0;
    logic [ITER_W-1:0]  iterations = '0;
    logic               busy, done, err, result_bank, m_en, v_ren, v_we, acc_valid, acc_last;
    logic [MADDR_W-1:0] m_addr;
    logic [VADDR_W-1:0] v_raddr, v_waddr;
    logic [LANE_W-1:0]  wb_lane;

    mv_tile_sequencer #(
        .LANES(L), .COL_W(COL_W), .GRP_W(GRP_W), .ITER_W(ITER_W),
        .MADDR_W(MADDR_W), .VADDR_W(VADDR_W), .PIPE_LAT(P), .ACC_LAT(A)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cols(cols), .groups(groups), .iterations(iterations),
        .busy(busy), .done(done), .err(err), .result_bank(result_bank),
        .m_addr(m_addr), .m_en(m_en), .v_raddr(v_raddr), .v_ren(v_ren),
        .v_waddr(v_waddr), .v_we(v_we), .wb_lane(wb_lane),
        .acc_valid(acc_valid), .acc_last(acc_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int a; int b; int c; } ev_t;
    ev_t rd_q[$], acc_q[$], wr_q[$], dn_q[$];
    bit  rec = 1'b0;
    int  n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rec) begin
            if (m_en || v_ren)
                rd_q.push_back(ev_t'{cyc, int'(m_addr), int'(v_raddr), int'({m_en, v_ren})});
            if (acc_valid || acc_last)
                acc_q.push_back(ev_t'{cyc, int'(acc_valid), int'(acc_last), 0});
            if (v_we)
                wr_q.push_back(ev_t'{cyc, int'(v_waddr), int'(wb_lane), 0});
            if (done)
                dn_q.push_back(ev_t'{cyc, int'(err), int'(result_bank), int'(busy)});
        end
    end

    function automatic int ctl_word();
        return int'({busy, done, err, result_bank, m_en, v_ren, v_we, acc_valid, acc_last});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"},     ctl_word(), 0);
        check({tag, "_m_addr"},  int'(m_addr), 0);
        check({tag, "_v_raddr"}, int'(v_raddr), 0);
        check({tag, "_v_waddr"}, int'(v_waddr), 0);
        check({tag, "_wb_lane"}, int'(wb_lane), 0);
    endtask

    task automatic clear_queues();
        rd_q.delete(); acc_q.delete(); wr_q.delete(); dn_q.delete();
    endtask

    task automatic issue_start(input int c, input int g, input int it);
        cols       = COL_W'(c);
        groups     = GRP_W'(g);
        iterations = ITER_W'(it);
        start      = 1'b1;
    endtask

    // Full run of a legal configuration; inj pulses a different start while busy.
    task automatic run_cfg(input int c, input int g, input int it, input bit inj);
        int  start_cyc, gc, nrd, nwr;
        bit  seen;
        clear_queues();
        @(negedge clk);
        issue_start(c, g, it);
        rec       = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inj && k == 2) issue_start(c + 3, g + 1, it + 2);
            else if (inj && k == 3) start = 1'b0;
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
        @(negedge clk);
        rec = 1'b0;

        gc  = g * c;
        nrd = it * gc;
        nwr = it * g * L;
        check("rd_count",    rd_q.size(),  nrd);
        check("acc_count",   acc_q.size(), nrd);
        check("wr_count",    wr_q.size(),  nwr);
        check("done_pulses", dn_q.size(),  1);
        if (rd_q.size() == nrd && acc_q.size() == nrd && wr_q.size() == nwr) begin
            for (int i = 0; i < nrd; i++) begin
                int itr, r, col;
                itr = i / gc;
                r   = i % gc;
                col = r % c;
                check("m_addr",  rd_q[i].a, r);
                check("v_raddr", rd_q[i].b, (itr % 2) * BANK_SPAN + col);
                check("rd_en",   rd_q[i].c, 3);
                if (i == 0)
                    check("first_read_cyc", rd_q[i].cyc, start_cyc);
                else if (r != 0)
                    check("read_back_to_back", rd_q[i].cyc, rd_q[i-1].cyc + 1);
                else
                    check("read_after_last_write", int'(rd_q[i].cyc > wr_q[itr*g*L - 1].cyc), 1);
                check("acc_cyc",   acc_q[i].cyc, rd_q[i].cyc + P);
                check("acc_valid", acc_q[i].a, 1);
                check("acc_last",  acc_q[i].b, int'(col == c - 1));
            end
            for (int j = 0; j < nwr; j++) begin
                int itr, r, gg, ln, wbk, li;
                itr = j / (g * L);
                r   = j % (g * L);
                gg  = r / L;
                ln  = r % L;
                wbk = (itr % 2 == 0) ? 1 : 0;
                li  = itr * gc + gg * c + c - 1;
                check("v_waddr", wr_q[j].a, wbk * BANK_SPAN + gg * L + ln);
                check("wb_lane", wr_q[j].b, ln);
                check("wr_cyc",  wr_q[j].cyc, rd_q[li].cyc + P + A + ln);
            end
        end
        if (dn_q.size() == 1) begin
            check("done_err",         dn_q[0].a, 0);
            check("done_result_bank", dn_q[0].b, it % 2);
            check("done_busy",        dn_q[0].c, 0);
            if (nwr > 0 && wr_q.size() == nwr)
                check("done_after_wb", int'(dn_q[0].cyc > wr_q[nwr-1].cyc), 1);
        end
    endtask

    // Illegal configuration: immediate done with err, no traffic at all.
    task automatic run_err(input int c, input int g, input int it);
        clear_queues();
        @(negedge clk);
        issue_start(c, g, it);
        rec = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_done",   int'(done), 1);
        check("err_flag",   int'(err), 1);
        check("err_busy",   int'(busy), 0);
        @(negedge clk);
        check("err_done_once", int'(done), 0);
        check("err_sticky",    int'(err), 1);
        repeat (3) @(negedge clk);
        rec = 1'b0;
        check("err_no_reads",  rd_q.size(), 0);
        check("err_no_writes", wr_q.size(), 0);
    endtask

    initial begin
        int stray;
        bit seen_en;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        run_cfg(3, 2, 1, 1'b0);
        run_cfg(3, 2, 3, 1'b0);
        run_cfg(3, 2, 2, 1'b1);
        run_cfg(2, 1, 1, 1'b0);
        run_cfg(8, 8, 1, 1'b0);

        run_err(1, 2, 1);
        run_err(3, 0, 1);
        run_err(3, 2, 0);
        run_err(9, 8, 1);
        run_err(65, 1, 1);

        // abort mid-FEED
        @(negedge clk);
        issue_start(4, 3, 2);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctl",     ctl_word(), 'h0C0);
        check("abort_m_addr",  int'(m_addr), 0);
        check("abort_v_waddr", int'(v_waddr), 0);
        @(negedge clk);
        check("abort_done_once", int'(done), 0);
        stray = 0;
        repeat (2 * (P + A + L)) begin
            @(negedge clk);
            if (v_we || m_en || acc_valid || done) stray++;
        end
        check("abort_no_stray", stray, 0);
        run_cfg(3, 2, 1, 1'b0);

        // abort and start together in IDLE
        @(negedge clk);
        issue_start(3, 2, 1);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_start_busy", int'(busy), 0);
        check("idle_abort_start_done", int'(done), 0);

        // reset pulse mid-DRAIN
        @(negedge clk);
        issue_start(3, 2, 1);
        @(negedge clk);
        start   = 1'b0;
        seen_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (seen_en && !m_en) break;
            if (m_en) seen_en = 1'b1;
            @(negedge clk);
        end
        check("reached_drain", int'(busy && seen_en && !m_en), 1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("drain_reset");
        rstn  = 1'b1;
        stray = 0;
        repeat (3 * (P + A + L)) begin
            @(negedge clk);
            if (v_we || done || busy || acc_valid) stray++;
        end
        check("reset_no_stray", stray, 0);

        for (int n = 0; n < 12; n++) begin
            run_cfg(int'($urandom_range(2, 8)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
